// File: rtl/mem_freeze_ctrl.sv
// mem_freeze_ctrl
// Sequences the memory accesses for one pipeline advance on a single-port handshaked memory.
// The data access goes first, then the instruction fetch. While an access is outstanding,
// `freeze` holds every pipeline register.
// A watchdog bounds each access to TIMEOUT request cycles. If an access expires, the sticky
// memErr flag is set and the access completes with zero data.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   fetchEn, pcAddr          fetch request and fetch address
//   memRd, memWr, dAddr,     MEM-stage load/store request, address and store data
//   dWdata
//   mReq, mWe, mAddr,        memory request channel (all zero while idle)
//   mWdata
//   mAck, mRdata             memory completion and read data
//   freeze                   stall for the pipeline registers
//   instr, rdata             last fetched instruction / last load data (registered)
//   memErr                   sticky watchdog timeout flag
module mem_freeze_ctrl #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetchEn,
    input  logic [ADDR_W-1:0] pcAddr,
    input  logic              memRd,
    input  logic              memWr,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [DATA_W-1:0] dWdata,
    output logic              mReq,
    output logic              mWe,
    output logic [ADDR_W-1:0] mAddr,
    output logic [DATA_W-1:0] mWdata,
    input  logic              mAck,
    input  logic [DATA_W-1:0] mRdata,
    output logic              freeze,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] rdata,
    output logic              memErr
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StDAcc, StIAcc, StRelease} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] daddr_q, daddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic              fpend_q, fpend_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic any_req;
    logic timeout;
    logic done;

    assign any_req = fetchEn | memRd | memWr;
    // The cycle in which the counter would reach TIMEOUT is the last one allowed.
    // An ack in that same cycle still counts as success.
    assign timeout = (cnt_q == CntW'(TIMEOUT - 1)) && !mAck;
    assign done    = mAck | timeout;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        daddr_d = daddr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        fpend_d = fpend_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mReq    = 1'b0;
        mWe     = 1'b0;
        mAddr   = '0;
        mWdata  = '0;
        freeze  = 1'b0;

        unique case (state_q)
            StIdle: begin
                freeze = any_req;
                if (any_req) begin
                    pc_d    = pcAddr;
                    daddr_d = dAddr;
                    wdata_d = dWdata;
                    wr_d    = memWr;
                    rd_d    = memRd;
                    fpend_d = fetchEn;
                    cnt_d   = '0;
                    state_d = (memRd | memWr) ? StDAcc : StIAcc;
                end
            end
            StDAcc: begin
                mReq   = 1'b1;
                mWe    = wr_q;
                mAddr  = daddr_q;
                mWdata = wdata_q;
                freeze = 1'b1;
                if (done) begin
                    if (rd_q) begin
                        rdata_d = mAck ? mRdata : '0;
                    end
                    if (!mAck) begin
                        err_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = fpend_q ? StIAcc : StRelease;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StIAcc: begin
                mReq   = 1'b1;
                mAddr  = pc_q;
                freeze = 1'b1;
                if (done) begin
                    instr_d = mAck ? mRdata : '0;
                    if (!mAck) begin
                        err_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = StRelease;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (rst) begin
            freeze = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= '0;
            daddr_q <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            fpend_q <= 1'b0;
            cnt_q   <= '0;
            instr_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            daddr_q <= daddr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            fpend_q <= fpend_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign instr  = instr_q;
    assign rdata  = rdata_q;
    assign memErr = err_q;

endmodule

// File: tb/tb_mem_freeze_ctrl.sv
// Testbench for mem_freeze_ctrl.
// The model works per advance. Each request cycle, access, and release produces one row of
// expected outputs. A single compare process checks the DUT against each row at negedge.
module tb_mem_freeze_ctrl;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fetchEn = 1'b0, memRd = 1'b0, memWr = 1'b0, mAck = 1'b0;
    logic [AW-1:0] pcAddr = '0, dAddr = '0;
    logic [DW-1:0] dWdata = '0, mRdata = '0;
    logic          mReq, mWe, freeze, memErr;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mWdata, instr, rdata;

    always #5 clk = ~clk;

    mem_freeze_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .fetchEn(fetchEn), .pcAddr(pcAddr), .memRd(memRd),
        .memWr(memWr), .dAddr(dAddr), .dWdata(dWdata), .mReq(mReq), .mWe(mWe),
        .mAddr(mAddr), .mWdata(mWdata), .mAck(mAck), .mRdata(mRdata), .freeze(freeze),
        .instr(instr), .rdata(rdata), .memErr(memErr)
    );

    typedef struct {
        logic          only_frz;  // reset cycle: only freeze is defined
        logic          wd_dc;     // mWdata not defined (fetch access)
        logic          frz;
        logic          mreq;
        logic          mwe;
        logic [AW-1:0] maddr;
        logic [DW-1:0] mwdata;
        logic [DW-1:0] instr;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          cur;
    int            total = 0;
    int            bad = 0;
    int            frz_cnt = 0;
    logic [DW-1:0] instr_m = '0, rdata_m = '0;
    logic          err_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (freeze === 1'b1) frz_cnt++;
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            chk("freeze", 32'(freeze), 32'(cur.frz));
            if (!cur.only_frz) begin
                chk("mReq", 32'(mReq), 32'(cur.mreq));
                chk("mWe", 32'(mWe), 32'(cur.mwe));
                chk("mAddr", 32'(mAddr), 32'(cur.maddr));
                if (!cur.wd_dc) chk("mWdata", 32'(mWdata), 32'(cur.mwdata));
                chk("instr", 32'(instr), 32'(cur.instr));
                chk("rdata", 32'(rdata), 32'(cur.rdata));
                chk("memErr", 32'(memErr), 32'(cur.err));
            end
        end
    end

    function automatic exp_t mk(input logic f, input logic rq, input logic we,
                                input logic [AW-1:0] a, input logic [DW-1:0] wd);
        exp_t e;
        e.only_frz = 1'b0;
        e.wd_dc    = 1'b0;
        e.frz      = f;
        e.mreq     = rq;
        e.mwe      = we;
        e.maddr    = a;
        e.mwdata   = wd;
        e.instr    = instr_m;
        e.rdata    = rdata_m;
        e.err      = err_m;
        return e;
    endfunction

    // One clock cycle with explicit request inputs.
    task automatic drive(input logic fe, input logic rd, input logic wr, input logic [AW-1:0] pc,
                         input logic [AW-1:0] da, input logic [DW-1:0] dw, input logic ack,
                         input logic [DW-1:0] rdat, input exp_t e);
        @(posedge clk);
        #1;
        fetchEn = fe; memRd = rd; memWr = wr;
        pcAddr = pc; dAddr = da; dWdata = dw;
        mAck = ack; mRdata = rdat;
        exp_q.push_back(e);
    endtask

    // One clock cycle whose request inputs must be ignored.
    task automatic junk(input logic ack, input logic [DW-1:0] rdat, input exp_t e);
        logic r;
        r = 1'($urandom);
        drive(1'($urandom), r, !r && 1'($urandom), AW'($urandom), AW'($urandom),
              DW'($urandom), ack, rdat, e);
    endtask

    // One memory access: ack after w wait states, or never when w >= TO.
    task automatic access(input logic is_d, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wdat, input int w, input logic [DW-1:0] v,
                          input logic has_dest);
        int   n;
        logic ack;
        exp_t e;
        n = (w < TO) ? w + 1 : TO;
        for (int k = 0; k < n; k++) begin
            ack = (k == w);
            e = mk(1'b1, 1'b1, we, a, wdat);
            e.wd_dc = !is_d;
            junk(ack, ack ? v : DW'($urandom), e);
        end
        if (has_dest) begin
            if (is_d) rdata_m = (w < TO) ? v : '0;
            else      instr_m = (w < TO) ? v : '0;
        end
        if (w >= TO) err_m = 1'b1;
    endtask

    task automatic advance(input logic fe, input logic rd, input logic wr,
                           input logic [AW-1:0] pc, input logic [AW-1:0] da,
                           input logic [DW-1:0] dw, input int wd, input int wi,
                           input logic [DW-1:0] vd, input logic [DW-1:0] vi);
        logic req;
        req = fe | rd | wr;
        drive(fe, rd, wr, pc, da, dw, 1'($urandom), DW'($urandom), mk(req, 0, 0, '0, '0));
        if (!req) return;
        if (rd | wr) access(1'b1, wr, da, dw, wd, vd, rd);
        if (fe) access(1'b0, 1'b0, pc, '0, wi, vi, 1'b1);
        junk(1'($urandom), DW'($urandom), mk(0, 0, 0, '0, '0));
    endtask

    task automatic do_reset();
        exp_t e;
        e = mk(0, 0, 0, '0, '0);
        e.only_frz = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0, e);
            rst = 1'b1;
        end
        instr_m = '0; rdata_m = '0; err_m = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        fetchEn = 1'b0;
        exp_q.push_back(mk(0, 0, 0, '0, '0));
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    int f0;
    int op;

    initial begin
        do_reset();
        advance(0, 0, 0, '0, '0, '0, 0, 0, '0, '0);  // idle, reset values
        settle();

        f0 = frz_cnt;
        advance(1, 0, 0, 16'h0010, '0, '0, 0, 0, '0, 16'hA5A5);
        settle();
        chk("fetch_frozen", 32'(frz_cnt - f0), 32'd2);
        chk("fetch_instr_model", 32'(instr_m), 32'hA5A5);

        f0 = frz_cnt;
        advance(1, 1, 0, 16'h0011, 16'h0200, '0, 2, 2, 16'hBEEF, 16'h1357);
        settle();
        chk("ldfetch_frozen", 32'(frz_cnt - f0), 32'd7);
        chk("ldfetch_rdata_model", 32'(rdata_m), 32'hBEEF);

        f0 = frz_cnt;
        advance(0, 0, 1, '0, 16'h0300, 16'h1234, 0, 0, '0, '0);
        settle();
        chk("store_frozen", 32'(frz_cnt - f0), 32'd2);
        chk("store_instr_model", 32'(instr_m), 32'h1357);

        f0 = frz_cnt;
        advance(1, 0, 0, 16'h0040, '0, '0, 0, TO + 1, '0, '0);
        settle();
        chk("timeout_frozen", 32'(frz_cnt - f0), 32'(1 + TO));
        chk("timeout_err_model", 32'(err_m), 32'd1);
        chk("timeout_instr_model", 32'(instr_m), 32'd0);
        advance(1, 0, 0, 16'h0041, '0, '0, 0, 1, '0, 16'h0F0F);
        settle();

        do_reset();
        f0 = frz_cnt;
        advance(1, 0, 0, 16'h0050, '0, '0, 0, TO - 1, '0, 16'h4321);
        settle();
        chk("lastcyc_frozen", 32'(frz_cnt - f0), 32'(1 + TO));
        chk("lastcyc_err_model", 32'(err_m), 32'd0);

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 24) == 0) do_reset();
            op = int'($urandom_range(0, 2));
            advance(1'($urandom), op == 1, op == 2, AW'($urandom), AW'($urandom),
                    DW'($urandom),
                    ($urandom_range(0, 9) == 0) ? TO + 1 : int'($urandom_range(0, 3)),
                    ($urandom_range(0, 9) == 0) ? TO + 1 : int'($urandom_range(0, 3)),
                    DW'($urandom), DW'($urandom));
        end
        settle();

        // Reset in the middle of a data access abandons it.
        drive(1'b1, 1'b1, 1'b0, 16'h0060, 16'h0400, 16'h5555, 1'b0, '0,
              mk(1, 0, 0, '0, '0));
        for (int k = 0; k < 2; k++) junk(1'b0, '0, mk(1, 1, 0, 16'h0400, 16'h5555));
        begin
            exp_t e;
            e = mk(0, 0, 0, '0, '0);
            e.only_frz = 1'b1;
            drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0, e);
            rst = 1'b1;
        end
        instr_m = '0; rdata_m = '0; err_m = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back(mk(0, 0, 0, '0, '0));
        settle();
        settle();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
